// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_DW = 48;

    // One-hot (up to 8 lanes) to binary index; an all-zero input maps to 0.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter; master is the arbiter, slave the surroundings.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = DEFAULT_DW
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]    i_req_valid;
    logic [N*DW-1:0] i_req_data;
    logic [N-1:0]    o_req_ready;
    logic            i_fifo_full;
    logic            i_fifo_almst_full;
    logic            o_fifo_wr_en;
    logic [DW-1:0]   o_fifo_data;
    logic [N-1:0]    o_grant;
    logic [IW-1:0]   o_grant_id;

    modport master (
        input  i_req_valid, i_req_data, i_fifo_full, i_fifo_almst_full,
        output o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_grant_id
    );

    modport slave (
        output i_req_valid, i_req_data, i_fifo_full, i_fifo_almst_full,
        input  o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, wrapping around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            pos = IW'((32'(i_ptr) + i) % N);
            if (!found && i_req[pos]) begin
                found      = 1'b1;
                o_gnt[pos] = 1'b1;
            end
        end
    end

    assign o_gnt_idx = IW'(onehot_to_idx(8'(o_gnt)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among N requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = DEFAULT_DW,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned   IW        = $clog2(N);
    localparam int unsigned   CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] PTR_RST   = IW'(N - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [DW-1:0] data_q, data_d;

    logic          in_burst;
    logic          stall;
    logic          owner_valid;
    logic          accept;
    logic          release_c;
    logic          any_req;
    logic [DW-1:0] owner_data;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;

    assign in_burst    = (state_q == BURST);
    assign stall       = bus.i_fifo_full | bus.i_fifo_almst_full;
    assign owner_valid = |(bus.i_req_valid & grant_q);
    assign accept      = in_burst & ~stall & owner_valid;
    assign any_req     = |bus.i_req_valid;
    // A vanished owner releases even while stalled; a full burst releases only on its last beat.
    assign release_c   = in_burst & (~owner_valid | (accept & (cnt_q == LAST_BEAT)));
    assign pick_ptr    = in_burst ? grant_id_q : ptr_q;

    always_comb begin
        owner_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant_q[k]) owner_data = owner_data | bus.i_req_data[k*DW +: DW];
        end
    end

    rr_pick #(.N(N)) u_pick (
        .i_req     (bus.i_req_valid),
        .i_ptr     (pick_ptr),
        .o_gnt     (pick_gnt),
        .o_gnt_idx (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        wr_en_d    = accept;
        data_d     = accept ? owner_data : data_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = BURST;
                    grant_d    = pick_gnt;
                    grant_id_d = pick_idx;
                    cnt_d      = '0;
                end
            end
            BURST: begin
                if (accept) cnt_d = cnt_q + CW'(1);
                if (release_c) begin
                    ptr_d = grant_id_q;
                    cnt_d = '0;
                    if (any_req) begin
                        grant_d    = pick_gnt;
                        grant_id_d = pick_idx;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= PTR_RST;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
        end
    end

    assign bus.o_req_ready  = grant_q & {N{in_burst & ~stall}};
    assign bus.o_fifo_wr_en = wr_en_q;
    assign bus.o_fifo_data  = data_q;
    assign bus.o_grant      = grant_q;
    assign bus.o_grant_id   = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus random scoreboard bench for fifo_wr_arbiter (N=4, DW=48, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 48;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] sb[$];
    int unsigned   seq[N];
    int unsigned   acc_cnt[N];
    logic          acc_prev;
    logic [N-1:0]  acc_last;
    logic [N-1:0]  pend;
    logic [N*DW-1:0] pend_data;
    bit            model_en;
    int            rnd_mode;
    int            fifo_cnt;

    // Beat payload: source id in the top byte, 4*sequence number below.
    function automatic logic [DW-1:0] mk(input int unsigned k, input int unsigned s);
        return (DW'(k) << 40) | DW'(s * 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < N; k++) bus.i_req_data[k*DW +: DW] = mk(k, seq[k]);
    endtask

    // One clock: check writes/handshake at negedge, then update stimulus just after posedge.
    task automatic cycle();
        logic [N-1:0]  acc;
        logic [DW-1:0] exp;
        logic          wr_seen;
        bit            pop;
        @(negedge clk);
        acc     = '0;
        wr_seen = bus.o_fifo_wr_en;
        if (rst) begin
            sb.delete();
            acc_prev = 1'b0;
            pend     = '0;
        end else begin
            chk("wr_latency", 64'(bus.o_fifo_wr_en), 64'(acc_prev));
            if (bus.o_fifo_wr_en === 1'b1) begin
                chk("write_while_full", 64'(bus.i_fifo_full), 64'd0);
                if (model_en) chk("fifo_overflow", 64'(fifo_cnt >= 16), 64'd0);
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("wr_data", 64'(bus.o_fifo_data), 64'(exp));
                end
            end
            chk("grant_onehot", 64'($onehot0(bus.o_grant)), 64'd1);
            chk("ready_not_owner", 64'(bus.o_req_ready & ~bus.o_grant), 64'd0);
            if (bus.i_fifo_full || bus.i_fifo_almst_full)
                chk("ready_stalled", 64'(bus.o_req_ready), 64'd0);
            for (int k = 0; k < N; k++) begin
                if (pend[k]) begin
                    assert (bus.i_req_valid[k] && bus.i_req_data[k*DW +: DW] == pend_data[k*DW +: DW])
                    else $error("requester %0d broke the valid/data hold rule", k);
                end
            end
            acc       = bus.i_req_valid & bus.o_req_ready;
            pend      = bus.i_req_valid & ~bus.o_req_ready;
            pend_data = bus.i_req_data;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    sb.push_back(mk(k, seq[k]));
                    acc_cnt[k]++;
                    seq[k]++;
                end
            end
            acc_prev = |acc;
        end
        acc_last = acc;
        @(posedge clk);
        #1;
        if (model_en) begin
            pop      = (fifo_cnt > 0) && ($urandom_range(0, 2) == 0);
            fifo_cnt = fifo_cnt + int'(wr_seen) - int'(pop);
            bus.i_fifo_full       = (fifo_cnt >= 16);
            bus.i_fifo_almst_full = (fifo_cnt >= 15);
        end
        if (rnd_mode != 0) begin
            for (int k = 0; k < N; k++) begin
                if (!bus.i_req_valid[k] || acc_last[k])
                    bus.i_req_valid[k] = (rnd_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
            end
        end
        drive_data();
    endtask

    // Async reset assertion with immediate output checks, then a synchronous release.
    task automatic do_reset();
        rst                   = 1'b1;
        bus.i_req_valid       = '0;
        bus.i_fifo_full       = 1'b0;
        bus.i_fifo_almst_full = 1'b0;
        model_en              = 1'b0;
        rnd_mode              = 0;
        fifo_cnt              = 0;
        #1;
        chk("rst_wr_en", 64'(bus.o_fifo_wr_en), 64'd0);
        chk("rst_data", 64'(bus.o_fifo_data), 64'd0);
        chk("rst_grant", 64'(bus.o_grant), 64'd0);
        chk("rst_grant_id", 64'(bus.o_grant_id), 64'd0);
        chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
        cycle();
        cycle();
        for (int k = 0; k < N; k++) begin
            seq[k]     = 1;
            acc_cnt[k] = 0;
        end
        drive_data();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_prev = 1'b0;
        acc_last = '0;
        pend     = '0;
        do_reset();

        // Single requester: back-to-back bursts with no dead cycle at re-issue.
        bus.i_req_valid = 4'b0001;
        chk("a_dead_cycle", 64'(bus.o_grant), 64'd0);
        cycle();
        chk("a_grant", 64'(bus.o_grant), 64'b0001);
        for (int i = 0; i < 8; i++) begin
            chk("a_ready", 64'(bus.o_req_ready), 64'b0001);
            chk("a_grant_hold", 64'(bus.o_grant), 64'b0001);
            cycle();
        end
        chk("a_beats", 64'(acc_cnt[0]), 64'd8);

        // All requesters: rotation 0,1,2,3,0 with MB beats each.
        do_reset();
        bus.i_req_valid = 4'b1111;
        cycle();
        for (int i = 0; i < 20; i++) begin
            chk("b_grant_id", 64'(bus.o_grant_id), 64'((i / MB) % N));
            chk("b_grant", 64'(bus.o_grant), 64'(1 << ((i / MB) % N)));
            cycle();
        end
        for (int k = 0; k < N; k++) chk("b_beats", 64'(acc_cnt[k]), (k == 0) ? 64'd8 : 64'd4);

        // Almost-full stall after two beats freezes the burst.
        do_reset();
        bus.i_req_valid = 4'b0011;
        cycle();
        chk("c_grant", 64'(bus.o_grant), 64'b0001);
        cycle();
        cycle();
        bus.i_fifo_almst_full = 1'b1;
        #1;
        chk("c_ready_stall", 64'(bus.o_req_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 0) chk("c_wr_stop", 64'(bus.o_fifo_wr_en), 64'd0);
            chk("c_grant_held", 64'(bus.o_grant), 64'b0001);
        end
        chk("c_beats_frozen", 64'(acc_cnt[0]), 64'd2);
        bus.i_fifo_almst_full = 1'b0;
        cycle();
        chk("c_grant_3", 64'(bus.o_grant), 64'b0001);
        cycle();
        chk("c_rotate", 64'(bus.o_grant), 64'b0010);
        chk("c_beats", 64'(acc_cnt[0]), 64'd4);

        // Owner withdraws after one beat: requester 3 takes over, 1 waits a full burst.
        do_reset();
        bus.i_req_valid = 4'b1010;
        cycle();
        chk("d_grant1", 64'(bus.o_grant), 64'b0010);
        cycle();
        bus.i_req_valid[1] = 1'b0;
        chk("d_grant1_hold", 64'(bus.o_grant), 64'b0010);
        cycle();
        chk("d_grant3", 64'(bus.o_grant), 64'b1000);
        chk("d_grant3_id", 64'(bus.o_grant_id), 64'd3);
        bus.i_req_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("d_grant3_burst", 64'(bus.o_grant), 64'b1000);
            cycle();
        end
        chk("d_back_to_1", 64'(bus.o_grant), 64'b0010);

        // Reset mid-burst at count 3 while requester 2 owns the port.
        do_reset();
        bus.i_req_valid = 4'b0100;
        cycle();
        chk("e_grant2", 64'(bus.o_grant), 64'b0100);
        cycle();
        cycle();
        cycle();
        chk("e_inflight", 64'(bus.o_fifo_wr_en), 64'd1);
        do_reset();
        bus.i_req_valid = 4'b0101;
        cycle();
        chk("e_req0_first", 64'(bus.o_grant), 64'b0001);

        // Random traffic against a depth-16 FIFO model.
        do_reset();
        model_en = 1'b1;
        rnd_mode = 1;
        for (int i = 0; i < 1500; i++) cycle();
        rnd_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if (bus.i_req_valid == '0 && sb.size() == 0 && acc_prev == 1'b0) break;
            cycle();
        end
        chk("r_drain_valid", 64'(bus.i_req_valid), 64'd0);
        chk("r_drain_sb", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 48-bit synchronous FIFO between N producer requesters.
- Arbitration is round-robin with a bounded burst length.
- Backpressure comes from the FIFO full and almost-full flags; the data and write-enable to the FIFO are registered.
- Sits directly upstream of the FIFO in the same clock domain.

Parameters:
- N, 4, number of requesters (2..8)
- DW, 48, data width; must match the FIFO data width
- MAX_BURST, 4, maximum beats accepted per grant before re-arbitration (1..16)

Ports:
- i_clk  input  1  single clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_req_valid  input  N  per-requester beat valid
- i_req_data  input  N*DW  packed data; requester k occupies bits [k*DW +: DW]
- o_req_ready  output  N  per-requester accept; a beat transfers when valid and ready are both high on a rising edge
- i_fifo_full  input  1  FIFO full flag
- i_fifo_almst_full  input  1  FIFO has at most one free entry
- o_fifo_wr_en  output  1  registered FIFO write enable
- o_fifo_data  output  DW  registered FIFO write data
- o_grant  output  N  one-hot current owner; all zero when idle
- o_grant_id  output  $clog2(N)  index of owner; 0 when idle

Behaviour:
- Reset (async assert, released synchronously to i_clk):
  - o_fifo_wr_en=0, o_fifo_data=0, o_grant=0, o_grant_id=0, burst count=0, state=IDLE.
  - Round-robin pointer = N-1, so requester 0 wins first.
- Reset mid-burst: the in-flight registered write is discarded (o_fifo_wr_en drops immediately); no partial state survives.
- stall = i_fifo_full | i_fifo_almst_full.
- o_req_ready[k] = o_grant[k] & ~stall & (state==BURST). This is combinational from registered grant and FIFO flags; there is no combinational path from i_req_valid.
- Accept (beat transfer):
  - Registered next edge: o_fifo_wr_en=1, o_fifo_data=owner's data.
  - Latency is exactly 1 cycle, accept to write.
  - With no accept, o_fifo_wr_en=0 and o_fifo_data holds its last value.
- Safety: almost-full guarantees room for the one in-flight registered write. The FIFO must never see a write while full.
- FSM state IDLE:
  - No grant.
  - If any i_req_valid, select the winner by round-robin starting from pointer+1. Next edge: grant winner, go to BURST, burst count=0.
  - Idle-to-grant costs one dead cycle.
- FSM state BURST:
  - Each accept increments the burst count.
  - A release occurs when either:
    - a beat is accepted with count==MAX_BURST-1, or
    - the owner's i_req_valid is low, which releases regardless of stall.
  - On release:
    - The pointer updates to the owner's index.
    - The next winner is computed the same cycle from current i_req_valid, starting at owner+1. The owner is therefore lowest priority but still eligible if it is the only requester.
    - Next edge: new grant, count=0.
    - With no requesters, go to IDLE and clear the grant.
  - While stalled, the count freezes and the grant is held; stalling alone never forces a release.
- Grant changes only at release or IDLE exit; o_grant is always one-hot or zero.
- Requester obligations: i_req_data must be stable while valid and not ready; valid must not be withdrawn mid-beat. Violations are reported by a bench assertion, and the RTL need not tolerate them.
- Burst count width is $clog2(MAX_BURST+1); wrap-around is impossible because release occurs at MAX_BURST-1.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, BURST};
  - default DW=48 constant;
  - a function computing the one-hot-to-index conversion.
- One sub-module rr_pick: combinational.
  - Inputs: req[N], ptr index.
  - Outputs: one-hot winner and its index, searching from ptr+1 with wrap.
  - Reused by other arbiters.
- Top module: FSM, counter, pointer and output registers.

Test Plan:
- Reset, then requester 0 only valid with data 0x04, 0x08, 0x0C, ... continuously:
  - o_grant=0001 two edges after reset release;
  - writes appear in order with 1-cycle latency;
  - grant is re-issued to requester 0 every 4 beats;
  - no dead cycle at re-issue.
- Requesters 0..3 all valid continuously, MAX_BURST=4:
  - grants rotate 0,1,2,3,0 with exactly 4 writes each;
  - o_grant_id tracks the owner;
  - FIFO data shows each source's sequence contiguous.
- Hold i_fifo_almst_full=1 for 5 cycles mid-burst after 2 beats:
  - o_req_ready=0 and o_fifo_wr_en=0 one edge later;
  - count stays 2;
  - after deassert, exactly 2 more beats, then rotation.
- Owner 1 drops valid after 1 beat while requester 3 is valid: next edge o_grant=1000, and requester 1 loses priority.
- Assert i_rst for 1 cycle mid-burst at count=3:
  - all outputs zero immediately;
  - after release, requester 0 wins first even if requester 2 was the owner.
- Scoreboard, random valids, random full/almost-full with a FIFO model of depth 16:
  - zero writes while full;
  - every accepted beat is written exactly once, in per-source order.
